// File: rtl/cve2_mem_resp_pkg.sv
// rtl/cve2_mem_resp_pkg.sv - shared types and limits for the memory responder
package cve2_mem_resp_pkg;

  localparam int MaxRspLatency = 4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  typedef enum logic {
    IDLE,
    WAIT
  } gnt_state_e;

endpackage

// File: rtl/cve2_mem_responder_if.sv
// rtl/cve2_mem_responder_if.sv - request/grant/rvalid bus between core port and responder
interface cve2_mem_responder_if;

  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

endinterface

// File: rtl/cve2_mem_resp_pipe.sv
// rtl/cve2_mem_resp_pipe.sv - fixed-depth response delay line, reset clears valid bits only
module cve2_mem_resp_pipe
  import cve2_mem_resp_pkg::*;
#(
  parameter int Depth = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  rsp_t in_rsp,
  output rsp_t out_rsp
);

  logic [Depth-1:0] vld;
  logic             err_q  [Depth];
  logic [31:0]      data_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld <= '0;
    end else begin
      vld[0] <= in_rsp.valid;
      for (int i = 1; i < Depth; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    err_q[0]  <= in_rsp.err;
    data_q[0] <= in_rsp.rdata;
    for (int i = 1; i < Depth; i++) begin
      err_q[i]  <= err_q[i-1];
      data_q[i] <= data_q[i-1];
    end
  end

  assign out_rsp.valid = vld[Depth-1];
  assign out_rsp.err   = err_q[Depth-1];
  assign out_rsp.rdata = data_q[Depth-1];

endmodule

// File: rtl/cve2_mem_responder.sv
// rtl/cve2_mem_responder.sv - single-port SRAM responder with grant wait-states and fixed response latency
module cve2_mem_responder
  import cve2_mem_resp_pkg::*;
#(
  parameter int          MemWords   = 1024,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter int          GntWait    = 0,
  parameter int          RspLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cve2_mem_responder_if.slave  bus
);

  localparam int          AW      = $clog2(MemWords);
  localparam int          Lat     = (RspLatency > MaxRspLatency) ? MaxRspLatency : RspLatency;
  localparam logic [32:0] Limit   = {1'b0, BaseAddr} + 33'(4 * MemWords);
  localparam logic [2:0]  CntLast = 3'(GntWait - 1);

  gnt_state_e  state;
  logic [2:0]  cnt;
  logic        rdy;
  logic        gnt;
  logic        accept;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [31:0] mem [MemWords];
  rsp_t        rsp_in;
  rsp_t        rsp_out;

  // rdy is the registered "cnt will equal GntWait-1 while in WAIT" flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      rdy   <= 1'b0;
    end else if (GntWait != 0) begin
      case (state)
        IDLE: begin
          if (bus.req_i) begin
            state <= WAIT;
            cnt   <= '0;
            rdy   <= (GntWait == 1);
          end
        end
        WAIT: begin
          if (!bus.req_i || rdy) begin
            state <= IDLE;
            cnt   <= '0;
            rdy   <= 1'b0;
          end else begin
            cnt <= cnt + 3'd1;
            rdy <= ((cnt + 3'd1) == CntLast);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = (GntWait == 0) ? bus.req_i : (bus.req_i & rdy);
  assign bus.gnt_o = gnt;
  assign accept    = bus.req_i & gnt;

  assign in_range = ({1'b0, bus.addr_i} >= {1'b0, BaseAddr}) &&
                    ({1'b0, bus.addr_i} < Limit) &&
                    (bus.addr_i[1:0] == 2'b00);
  assign idx      = bus.addr_i[AW+1:2];

  always_ff @(posedge clk_i) begin
    if (accept && in_range && bus.we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.be_i[k]) begin
          mem[idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
        end
      end
    end
  end

  // the read word is captured into the first pipe stage at the grant edge
  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = accept;
    rsp_in.err   = accept & ~in_range;
    if (accept && in_range && !bus.we_i) begin
      rsp_in.rdata = mem[idx];
    end
  end

  cve2_mem_resp_pipe #(
    .Depth (Lat)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .in_rsp  (rsp_in),
    .out_rsp (rsp_out)
  );

  assign bus.rvalid_o = rsp_out.valid;
  assign bus.rdata_o  = rsp_out.valid ? rsp_out.rdata : 32'h0;
  assign bus.err_o    = rsp_out.valid & rsp_out.err;

endmodule

// File: tb/tb_cve2_mem_responder.sv
// tb/tb_cve2_mem_responder.sv - self-checking bench for cve2_mem_responder
module tb_cve2_mem_responder;

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  localparam logic [31:0] BASE_D = 32'h0000_1000;

  logic clk;
  logic rst;
  logic rst_c;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_on;
  vec_t vec [13];
  exp_t exp_q [$];
  logic [31:0] mdl [16];

  cve2_mem_responder_if ia ();
  cve2_mem_responder_if ib ();
  cve2_mem_responder_if ic ();
  cve2_mem_responder_if id ();

  cve2_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .GntWait(0), .RspLatency(1))
    u_a (.clk_i(clk), .rst_i(rst), .bus(ia));
  cve2_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .GntWait(3), .RspLatency(1))
    u_b (.clk_i(clk), .rst_i(rst), .bus(ib));
  cve2_mem_responder #(.MemWords(1024), .BaseAddr(32'h0), .GntWait(0), .RspLatency(3))
    u_c (.clk_i(clk), .rst_i(rst_c), .bus(ic));
  cve2_mem_responder #(.MemWords(16), .BaseAddr(BASE_D), .GntWait(2), .RspLatency(2))
    u_d (.clk_i(clk), .rst_i(rst), .bus(id));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model of the D port: grant GntWait cycles after the request
  // appears, response RspLatency cycles after that, data from the model memory.
  task automatic d_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd);
    exp_t e;
    bit   inr;
    int   w;
    step();
    id.req_i = 1'b1; id.we_i = we; id.be_i = be; id.addr_i = addr; id.wdata_i = wd;
    inr = (addr >= BASE_D) && (addr < BASE_D + 32'd64) && (addr % 4 == 0);
    e.due = cyc + 2 + 2;
    e.err = !inr;
    e.data = 32'h0;
    if (inr) begin
      w = int'((addr - BASE_D) / 4);
      if (we) begin
        for (int k = 0; k < 4; k++) if (be[k]) mdl[w][8*k +: 8] = wd[8*k +: 8];
      end else begin
        e.data = mdl[w];
      end
    end
    exp_q.push_back(e);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      @(negedge clk);
      chk("d_gnt", {31'h0, id.gnt_o}, {31'h0, k == 2});
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("d_rvalid", {31'h0, id.rvalid_o}, 32'h1);
        chk("d_rdata", id.rdata_o, exp_q[0].data);
        chk("d_err", {31'h0, id.err_o}, {31'h0, exp_q[0].err});
        void'(exp_q.pop_front());
      end else begin
        chk("d_idle_rvalid", {31'h0, id.rvalid_o}, 32'h0);
        chk("d_idle_rdata", id.rdata_o, 32'h0);
      end
    end
  end

  initial begin
    logic [9:0]  rp;
    logic [9:0]  gp;
    logic [9:0]  vp;
    logic [31:0] a;
    int          r;
    checks = 0; errors = 0; mon_on = 1'b0;

    vec[0]  = '{1'b1, 1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0};
    vec[1]  = '{1'b1, 1'b0, 4'hF, 32'h10,       32'h0,        1'b1, 1'b1, 32'h0,        1'b0};
    vec[2]  = '{1'b1, 1'b1, 4'hF, 32'h20,       32'h11223344, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0};
    vec[3]  = '{1'b1, 1'b1, 4'h5, 32'h20,       32'hAABBCCDD, 1'b1, 1'b1, 32'h0,        1'b0};
    vec[4]  = '{1'b1, 1'b0, 4'h0, 32'h20,       32'h0,        1'b1, 1'b1, 32'h0,        1'b0};
    vec[5]  = '{1'b1, 1'b0, 4'hF, 32'h40010000, 32'h0,        1'b1, 1'b1, 32'h11BB33DD, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 4'hF, 32'h2,        32'h0,        1'b1, 1'b1, 32'h0,        1'b1};
    vec[7]  = '{1'b1, 1'b1, 4'hF, 32'h40000020, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0,        1'b1};
    vec[8]  = '{1'b1, 1'b0, 4'h0, 32'h20,       32'h0,        1'b1, 1'b1, 32'h0,        1'b1};
    vec[9]  = '{1'b1, 1'b1, 4'h0, 32'h20,       32'h0,        1'b1, 1'b1, 32'h11BB33DD, 1'b0};
    vec[10] = '{1'b1, 1'b0, 4'hF, 32'h20,       32'h0,        1'b1, 1'b1, 32'h0,        1'b0};
    vec[11] = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h11BB33DD, 1'b0};
    vec[12] = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0};

    ia.req_i = 1'b1; ia.we_i = 1'b0; ia.be_i = 4'h0; ia.addr_i = 32'h0; ia.wdata_i = 32'h0;
    ib.req_i = 1'b1; ib.we_i = 1'b1; ib.be_i = 4'h0; ib.addr_i = 32'h0; ib.wdata_i = 32'h0;
    ic.req_i = 1'b0; ic.we_i = 1'b0; ic.be_i = 4'h0; ic.addr_i = 32'h0; ic.wdata_i = 32'h0;
    id.req_i = 1'b0; id.we_i = 1'b0; id.be_i = 4'h0; id.addr_i = 32'h0; id.wdata_i = 32'h0;
    rst = 1'b1; rst_c = 1'b1;

    // reset values
    step();
    @(negedge clk);
    chk("rst_a_gnt", {31'h0, ia.gnt_o}, 32'h1);
    chk("rst_b_gnt", {31'h0, ib.gnt_o}, 32'h0);
    chk("rst_a_rvalid", {31'h0, ia.rvalid_o}, 32'h0);
    chk("rst_a_rdata", ia.rdata_o, 32'h0);
    chk("rst_c_rvalid", {31'h0, ic.rvalid_o}, 32'h0);
    chk("rst_d_err", {31'h0, id.err_o}, 32'h0);
    ia.req_i = 1'b0; ib.req_i = 1'b0;
    step();
    rst = 1'b0; rst_c = 1'b0;

    // table-driven vectors, GntWait=0, RspLatency=1
    for (int i = 0; i < 13; i++) begin
      step();
      ia.req_i = vec[i].req; ia.we_i = vec[i].we; ia.be_i = vec[i].be;
      ia.addr_i = vec[i].addr; ia.wdata_i = vec[i].wdata;
      @(negedge clk);
      chk($sformatf("a_gnt[%0d]", i), {31'h0, ia.gnt_o}, {31'h0, vec[i].gnt});
      chk($sformatf("a_rvalid[%0d]", i), {31'h0, ia.rvalid_o}, {31'h0, vec[i].rvalid});
      chk($sformatf("a_rdata[%0d]", i), ia.rdata_o, vec[i].rdata);
      chk($sformatf("a_err[%0d]", i), {31'h0, ia.err_o}, {31'h0, vec[i].err});
    end

    // GntWait=3: held request with back-to-back, then drop-and-re-raise
    for (int s = 0; s < 2; s++) begin
      rp = (s == 0) ? 10'b0011111111 : 10'b0011110011;
      gp = (s == 0) ? 10'b0010001000 : 10'b0010000000;
      vp = (s == 0) ? 10'b0100010000 : 10'b0100000000;
      for (int c = 0; c < 10; c++) begin
        step();
        ib.req_i = rp[c];
        @(negedge clk);
        chk($sformatf("b%0d_gnt[%0d]", s, c), {31'h0, ib.gnt_o}, {31'h0, gp[c]});
        chk($sformatf("b%0d_rvalid[%0d]", s, c), {31'h0, ib.rvalid_o}, {31'h0, vp[c]});
      end
    end

    // RspLatency=3: preload, then four back-to-back reads
    for (int c = 0; c < 8; c++) begin
      step();
      ic.req_i = (c < 4); ic.we_i = 1'b1; ic.be_i = 4'hF;
      ic.addr_i = 32'(4 * c); ic.wdata_i = 32'(c + 1);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      ic.req_i = (c < 4); ic.we_i = 1'b0; ic.addr_i = 32'(4 * c);
      @(negedge clk);
      chk($sformatf("c_rvalid[%0d]", c), {31'h0, ic.rvalid_o}, {31'h0, (c >= 3 && c <= 6)});
      chk($sformatf("c_rdata[%0d]", c), ic.rdata_o, (c >= 3 && c <= 6) ? 32'(c - 2) : 32'h0);
    end

    // reset one cycle after a read grant; read granted as reset releases is served
    for (int c = 0; c < 7; c++) begin
      step();
      ic.req_i = (c == 0 || c == 3); ic.we_i = 1'b0; ic.addr_i = (c == 0) ? 32'h8 : 32'h4;
      if (c == 1) rst_c = 1'b1;
      if (c == 3) rst_c = 1'b0;
      @(negedge clk);
      if (c >= 1) begin
        chk($sformatf("cr_rvalid[%0d]", c), {31'h0, ic.rvalid_o}, {31'h0, c == 6});
        chk($sformatf("cr_rdata[%0d]", c), ic.rdata_o, (c == 6) ? 32'h2 : 32'h0);
        chk($sformatf("cr_err[%0d]", c), {31'h0, ic.err_o}, 32'h0);
      end
    end

    // randomized traffic on D against the transaction model
    mon_on = 1'b1;
    for (int w = 0; w < 16; w++) d_txn(1'b1, 4'hF, BASE_D + 32'(4 * w), $urandom);
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE_D + 32'(4 * $urandom_range(0, 15));
      else if (r == 7) a = BASE_D + 32'h40 + 32'(4 * $urandom_range(0, 3));
      else if (r == 8) a = BASE_D - 32'h10 + 32'(4 * $urandom_range(0, 3));
      else             a = BASE_D + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      d_txn($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), a, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        step();
        id.req_i = 1'b0;
      end
    end
    step();
    id.req_i = 1'b0;
    repeat (6) begin
      step();
      @(negedge clk);
    end
    mon_on = 1'b0;
    chk("d_drain", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
